mux_arbiter: RTL and testbench

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arbiter.sv | 73 +++++++
 tb/tb_mux_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// Two-input valid/ready arbiter feeding a single registered output slot.
// Define MUX_ARBITER_RR_EN for round-robin on contention; default is fixed priority to channel 0.
module mux_arbiter #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_src;
  logic             r_last_grant;

  logic             w_slot_free;
  logic             w_grant;
  logic             w_xfer;

  // Grant selection; with no requester the select parks on the last winner.
  always_comb begin
    w_grant     = r_last_grant;
    w_slot_free = ~r_out_valid | out_ready;
    if (in0_valid && in1_valid) begin
`ifdef MUX_ARBITER_RR_EN
      w_grant = ~r_last_grant;
`else
      w_grant = 1'b0;
`endif
    end else if (in1_valid) begin
      w_grant = 1'b1;
    end else if (in0_valid) begin
      w_grant = 1'b0;
    end
    w_xfer = rst_n & w_slot_free & (in0_valid | in1_valid);
  end

  assign sel       = w_grant;
  assign in0_ready = w_xfer & ~w_grant;
  assign in1_ready = w_xfer & w_grant;

  // Output slot: load on transfer, drain when consumed, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_src    <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_xfer) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= w_grant ? in1_data : in0_data;
      r_out_src    <= w_grant;
      r_last_grant <= w_grant;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed self-checking bench for mux_arbiter (WIDTH=8); follows MUX_ARBITER_RR_EN if defined.
module tb_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in0_valid, in1_valid;
  logic [7:0] in0_data, in1_data;
  logic       in0_ready, in1_ready;
  logic       sel, out_valid, out_src, out_ready;
  logic [7:0] out_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in0_valid = 1'b1; in1_valid = 1'b1;
    in0_data = 8'h11; in1_data = 8'h22; out_ready = 1'b1;
    #1;
    total++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin bad++;
      $display("FAIL reset_ready0 got=%b%b want=00", in0_ready, in1_ready); end
    for (int i = 0; i < 2; i++) begin
      tick;
      total++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin bad++;
        $display("FAIL reset_ready cyc=%0d got=%b%b want=00", i, in0_ready, in1_ready); end
      total++; if (out_valid !== 1'b0) begin bad++;
        $display("FAIL reset_valid cyc=%0d got=%b want=0", i, out_valid); end
      total++; if (out_data !== 8'h00) begin bad++;
        $display("FAIL reset_data cyc=%0d got=%h want=00", i, out_data); end
    end
    rst_n = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0;
    #1;
    total++; if (sel !== 1'b1) begin bad++;
      $display("FAIL reset_idle_sel got=%b want=1", sel); end
  endtask

  task automatic test_single;
    in0_valid = 1'b1; in0_data = 8'hA5; out_ready = 1'b1;
    #1;
    total++; if (in0_ready !== 1'b1 || in1_ready !== 1'b0 || sel !== 1'b0) begin bad++;
      $display("FAIL single0_grant got rdy=%b%b sel=%b want rdy=10 sel=0", in0_ready, in1_ready, sel); end
    tick;
    total++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 1'b0) begin bad++;
      $display("FAIL single0_out got v=%b d=%h s=%b want v=1 d=a5 s=0", out_valid, out_data, out_src); end
    in0_valid = 1'b0;
    #1;
    total++; if (sel !== 1'b0) begin bad++;
      $display("FAIL single0_idle_sel got=%b want=0", sel); end
    in1_valid = 1'b1; in1_data = 8'h5A;
    #1;
    total++; if (in1_ready !== 1'b1 || in0_ready !== 1'b0 || sel !== 1'b1) begin bad++;
      $display("FAIL single1_grant got rdy=%b%b sel=%b want rdy=01 sel=1", in0_ready, in1_ready, sel); end
    tick;
    total++; if (out_valid !== 1'b1 || out_data !== 8'h5A || out_src !== 1'b1) begin bad++;
      $display("FAIL single1_out got v=%b d=%h s=%b want v=1 d=5a s=1", out_valid, out_data, out_src); end
    in1_valid = 1'b0;
  endtask

  task automatic test_both;
    logic g;
    logic [7:0] exp_d;
    rst_n = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0;
    tick;
    rst_n = 1'b1;
    in0_valid = 1'b1; in1_valid = 1'b1; in0_data = 8'h11; in1_data = 8'h22; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef MUX_ARBITER_RR_EN
      g = (k % 2 == 1);
`else
      g = 1'b0;
`endif
      exp_d = g ? 8'h22 : 8'h11;
      #1;
      total++; if (in1_ready !== g || in0_ready !== ~g || sel !== g) begin bad++;
        $display("FAIL both_grant k=%0d got rdy=%b%b sel=%b want grant=%b", k, in0_ready, in1_ready, sel, g); end
      tick;
      total++; if (out_data !== exp_d || out_src !== g || out_valid !== 1'b1) begin bad++;
        $display("FAIL both_out k=%0d got d=%h s=%b v=%b want d=%h s=%b v=1", k, out_data, out_src, out_valid, exp_d, g); end
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
  endtask

  task automatic test_hold;
    in0_valid = 1'b1; in0_data = 8'h3C; out_ready = 1'b1;
    tick;
    in0_valid = 1'b0; in1_valid = 1'b1; in1_data = 8'h77; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in1_ready !== 1'b0 || in0_ready !== 1'b0 || sel !== 1'b1) begin bad++;
        $display("FAIL hold_ready cyc=%0d got rdy=%b%b sel=%b want rdy=00 sel=1", i, in0_ready, in1_ready, sel); end
      tick;
      total++; if (out_data !== 8'h3C || out_valid !== 1'b1 || out_src !== 1'b0) begin bad++;
        $display("FAIL hold_out cyc=%0d got d=%h v=%b s=%b want d=3c v=1 s=0", i, out_data, out_valid, out_src); end
    end
    out_ready = 1'b1;
    #1;
    total++; if (in1_ready !== 1'b1) begin bad++;
      $display("FAIL hold_release_ready got=%b want=1", in1_ready); end
    tick;
    total++; if (out_data !== 8'h77 || out_src !== 1'b1 || out_valid !== 1'b1) begin bad++;
      $display("FAIL hold_release_out got d=%h s=%b v=%b want d=77 s=1 v=1", out_data, out_src, out_valid); end
    in1_valid = 1'b0;
  endtask

  task automatic test_drain;
    out_ready = 1'b1;
    tick;
    total++; if (out_valid !== 1'b0) begin bad++;
      $display("FAIL drain_valid got=%b want=0", out_valid); end
    tick;
    total++; if (out_valid !== 1'b0) begin bad++;
      $display("FAIL drain_idle_ready got=%b want=0", out_valid); end
    out_ready = 1'b0;
    tick;
    total++; if (out_valid !== 1'b0) begin bad++;
      $display("FAIL drain_idle_noready got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid;
    in0_valid = 1'b1; in0_data = 8'h99; out_ready = 1'b1;
    tick;
    total++; if (out_valid !== 1'b1 || out_data !== 8'h99) begin bad++;
      $display("FAIL rmid_setup got v=%b d=%h want v=1 d=99", out_valid, out_data); end
    rst_n = 1'b0; in1_valid = 1'b1; in0_data = 8'h11; in1_data = 8'h22; out_ready = 1'b0;
    #1;
    total++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin bad++;
      $display("FAIL rmid_ready got=%b%b want=00", in0_ready, in1_ready); end
    tick;
    total++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 1'b0) begin bad++;
      $display("FAIL rmid_out got v=%b d=%h s=%b want v=0 d=00 s=0", out_valid, out_data, out_src); end
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (in0_ready !== 1'b1 || in1_ready !== 1'b0 || sel !== 1'b0) begin bad++;
      $display("FAIL rmid_first_grant got rdy=%b%b sel=%b want rdy=10 sel=0", in0_ready, in1_ready, sel); end
    tick;
    total++; if (out_data !== 8'h11 || out_src !== 1'b0 || out_valid !== 1'b1) begin bad++;
      $display("FAIL rmid_first_out got d=%h s=%b v=%b want d=11 s=0 v=1", out_data, out_src, out_valid); end
    in0_valid = 1'b0; in1_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_both;
    test_hold;
    test_drain;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
